// File: rtl/seg7_scan_controller.sv
// Four-digit multiplexed 7-segment scanner with a frame-synchronous shadow register for writes.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank zero digits above the most-significant nonzero one.

module seg7_scan_controller #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    output logic        wr_ready,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    state_t        state, state_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          wrap;

    logic [15:0]   disp_data, disp_data_nxt, shadow_data, shadow_data_nxt;
    logic [3:0]    disp_dp, disp_dp_nxt, shadow_dp, shadow_dp_nxt;
    logic          pending, pending_nxt;
    logic          accept;

    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [3:0]    nib;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        wrap      = 1'b0;
        case (state)
            IDLE: begin
                idx_nxt = 2'd0;
                cnt_nxt = '0;
                if (enable) state_nxt = SHOW;
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    cnt_nxt = '0;
                    if (BLANK_CYCLES == 0) begin
                        idx_nxt = idx + 2'd1;
                        wrap    = (idx == 2'd3);
                    end else begin
                        state_nxt = BLANK;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = SHOW;
                    idx_nxt   = idx + 2'd1;
                    wrap      = (idx == 2'd3);
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = 2'd0;
            cnt_nxt   = '0;
            wrap      = 1'b0;
        end
    end

    // Display only changes at a frame wrap or while idle, so a frame is never mixed.
    always_comb begin
        accept          = wr_valid & ~pending;
        disp_data_nxt   = disp_data;
        disp_dp_nxt     = disp_dp;
        shadow_data_nxt = shadow_data;
        shadow_dp_nxt   = shadow_dp;
        pending_nxt     = pending;
        if (state == IDLE || state_nxt == IDLE) begin
            if (pending) begin
                disp_data_nxt = shadow_data;
                disp_dp_nxt   = shadow_dp;
            end
            pending_nxt = 1'b0;
            if (accept) begin
                disp_data_nxt   = wr_data;
                disp_dp_nxt     = wr_dp;
                shadow_data_nxt = wr_data;
                shadow_dp_nxt   = wr_dp;
            end
        end else begin
            if (wrap && pending) begin
                disp_data_nxt = shadow_data;
                disp_dp_nxt   = shadow_dp;
                pending_nxt   = 1'b0;
            end
            if (accept) begin
                shadow_data_nxt = wr_data;
                shadow_dp_nxt   = wr_dp;
                pending_nxt     = 1'b1;
            end
        end
    end

    // Outputs are decoded from next-state values and registered below.
    always_comb begin
        an_nxt  = 4'b1111;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        nib     = disp_data_nxt[{idx_nxt, 2'b00} +: 4];
        if (state_nxt == SHOW) begin
            an_nxt  = ~(4'b0001 << idx_nxt);
            seg_nxt = hex_to_seg(nib);
            dp_nxt  = ~disp_dp_nxt[idx_nxt];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (idx_nxt != 2'd0 && (disp_data_nxt >> {idx_nxt, 2'b00}) == 16'h0000) begin
                seg_nxt = 7'h7F;
                dp_nxt  = 1'b1;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= 2'd0;
            cnt         <= '0;
            disp_data   <= 16'h0000;
            disp_dp     <= 4'h0;
            shadow_data <= 16'h0000;
            shadow_dp   <= 4'h0;
            pending     <= 1'b0;
            an          <= 4'b1111;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_done  <= 1'b0;
            wr_ready    <= 1'b1;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            disp_data   <= disp_data_nxt;
            disp_dp     <= disp_dp_nxt;
            shadow_data <= shadow_data_nxt;
            shadow_dp   <= shadow_dp_nxt;
            pending     <= pending_nxt;
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
            frame_done  <= wrap;
            wr_ready    <= ~pending_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller (CLK_DIV=4, BLANK_CYCLES=1): each lit digit slot is
// popped from an expectation queue and compared as {an, seg, dp, length}.

module tb_seg7_scan_controller;

    localparam int CLK_DIV = 4;
    localparam int BLANK   = 1;
    localparam int FRAME   = 4 * (CLK_DIV + BLANK);

    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S8  = 7'b0000000;
    localparam logic [6:0] SA  = 7'b0001000;
    localparam logic [6:0] SB  = 7'b0000011;
    localparam logic [6:0] SC  = 7'b1000110;
    localparam logic [6:0] SD  = 7'b0100001;
    localparam logic [6:0] SE  = 7'b0000110;
    localparam logic [6:0] SF  = 7'b0001110;
    localparam logic [6:0] OFF = 7'h7F;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZB = OFF;
`else
    localparam logic [6:0] ZB = S0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = 16'h0;
    logic [3:0]  wr_dp = 4'h0;
    logic        wr_ready;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    typedef struct packed {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic [31:0] len;
    } slot_t;

    slot_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    seg7_scan_controller #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_dp(wr_dp), .wr_ready(wr_ready), .seg(seg),
        .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input int l);
        slot_t e;
        e.an  = a;
        e.seg = s;
        e.dp  = d;
        e.len = l;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input logic [3:0] dpb);
        push(4'b1110, s0, ~dpb[0], CLK_DIV);
        push(4'b1101, s1, ~dpb[1], CLK_DIV);
        push(4'b1011, s2, ~dpb[2], CLK_DIV);
        push(4'b0111, s3, ~dpb[3], CLK_DIV);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frame_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        check("frame_done_seen", frame_done, 1'b1);
    endtask

    // Monitor: slot capture, off-pattern legality and frame period.
    slot_t cur;
    int    cyc = 0;
    int    ref_cyc = 0;
    bit    ref_valid = 0;
    bit    fresh = 1;

    always @(negedge clk) begin
        slot_t got, e;
        cyc++;
        check("an_legal", an inside {4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111}, 1'b1);
        if (an == 4'b1111) check("off_pattern", {seg, dp}, {OFF, 1'b1});

        if (cur.len != 0 && {an, seg, dp} == {cur.an, cur.seg, cur.dp}) begin
            cur.len++;
        end else begin
            if (cur.len != 0) begin
                got = cur;
                if (exp_q.size() == 0) begin
                    check("unexpected_slot", got, '0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("slot an=%b", e.an), got, e);
                end
            end
            cur.len = 0;
            if (an != 4'b1111) begin
                cur.an  = an;
                cur.seg = seg;
                cur.dp  = dp;
                cur.len = 1;
            end
        end

        if (!rst_n || !enable) begin
            ref_valid = 0;
            fresh     = 1;
        end else if (frame_done) begin
            check("frame_done_an", an, 4'b1110);
            if (ref_valid) check("frame_period", cyc - ref_cyc, FRAME);
            ref_cyc   = cyc;
            ref_valid = 1;
            fresh     = 0;
        end else if (fresh && an == 4'b1110) begin
            ref_cyc   = cyc;
            ref_valid = 1;
            fresh     = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cur = '0;
        step(3);
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, OFF);
        check("rst_dp", dp, 1'b1);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;
        step(2);

        // Idle write of zero, then scan two frames of 0000.
        wr_valid = 1'b1; wr_data = 16'h0000; wr_dp = 4'b0000;
        step(1);
        wr_valid = 1'b0;
        push_frame(S0, ZB, ZB, ZB, 4'b0000);
        enable = 1'b1;
        step(1);
        wait_frame_done();
        push_frame(S0, ZB, ZB, ZB, 4'b0000);

        // Mid-frame write: held off until the wrap, then shown whole.
        step(7);
        wr_valid = 1'b1; wr_data = 16'hF81A; wr_dp = 4'b0100;
        step(1);
        wr_valid = 1'b0;
        check("wr_ready_pending", wr_ready, 1'b0);
        push(4'b1110, SA, 1'b1, CLK_DIV);
        push(4'b1101, S1, 1'b1, CLK_DIV);
        push(4'b1011, S8, 1'b0, 1);
        step(5);
        check("wr_ready_still_pending", wr_ready, 1'b0);
        wait_frame_done();
        check("wr_ready_after_wrap", wr_ready, 1'b1);

        // Accept 0012 then drop enable during digit 2; pending moves to display on idle.
        step(2);
        wr_valid = 1'b1; wr_data = 16'h0012; wr_dp = 4'b0000;
        step(1);
        wr_valid = 1'b0;
        check("wr_ready_pending2", wr_ready, 1'b0);
        step(7);
        enable = 1'b0;
        step(1);
        check("idle_an", an, 4'b1111);
        check("idle_seg", seg, OFF);
        check("idle_dp", dp, 1'b1);
        check("idle_wr_ready", wr_ready, 1'b1);
        step(3);

        // Re-enable restarts at digit 0 with the transferred value.
        push_frame(S2, S1, ZB, ZB, 4'b0000);
        enable = 1'b1;
        step(1);
        wait_frame_done();

        // Reset mid-SHOW of digit 1 with a pending write.
        push(4'b1110, S2, 1'b1, CLK_DIV);
        push(4'b1101, S1, 1'b1, 1);
        step(1);
        wr_valid = 1'b1; wr_data = 16'h5555; wr_dp = 4'b1111;
        step(1);
        wr_valid = 1'b0;
        check("wr_ready_pending3", wr_ready, 1'b0);
        step(4);
        rst_n = 1'b0;
        #1;
        check("async_rst_an", an, 4'b1111);
        check("async_rst_seg", seg, OFF);
        check("async_rst_dp", dp, 1'b1);
        check("async_rst_wr_ready", wr_ready, 1'b1);
        check("async_rst_frame_done", frame_done, 1'b0);
        step(1);
        rst_n = 1'b1;
        push_frame(S0, ZB, ZB, ZB, 4'b0000);
        wait_frame_done();
        push(4'b1110, S0, 1'b1, 2);
        step(1);
        enable = 1'b0;
        step(2);

        // Idle write loads the display directly.
        wr_valid = 1'b1; wr_data = 16'hBCDE; wr_dp = 4'b1001;
        step(1);
        wr_valid = 1'b0;
        check("idle_write_ready", wr_ready, 1'b1);
        push_frame(SE, SD, SC, SB, 4'b1001);
        enable = 1'b1;
        step(1);
        wait_frame_done();
        push(4'b1110, SE, 1'b0, 2);
        step(1);
        enable = 1'b0;
        step(4);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
